// File: rtl/pio_access_arbiter.sv
// pio_access_arbiter
// Two-master Avalon-MM arbiter in front of a single output PIO slave.
// Each grant runs a fixed three-phase sequence: IDLE (arbitrate and
// capture), ISSUE (one PIO access), DONE (one-cycle completion to the
// winner). Output timing follows directly from the current phase.
module pio_access_arbiter #(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  // master A (HPS lightweight bridge)
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  // master B (fabric control FSM)
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  // PIO slave
  output logic [ADDR_W-1:0] pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  state_t              state;
  state_t              state_nxt;
  gnt_t                grant;
  gnt_t                grant_nxt;
  gnt_t                last_grant;
  logic                take;
  logic                is_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   a_rd_q;
  logic [DATA_W-1:0]   b_rd_q;
  logic                req_a;
  logic                req_b;

  // A read with write also high is treated as a write; both count as a request.
  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // Phase register; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration and phase sequencing.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          take = 1'b1;
          if (FIXED_PRIO != 0) begin
            grant_nxt = GNT_A;
          end else begin
            grant_nxt = (last_grant == GNT_A) ? GNT_B : GNT_A;
          end
        end else if (req_a) begin
          take      = 1'b1;
          grant_nxt = GNT_A;
        end else if (req_b) begin
          take      = 1'b1;
          grant_nxt = GNT_B;
        end
        if (take) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read-data return registers and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= GNT_A;
      last_grant <= GNT_B;
      is_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rd_q     <= '0;
      b_rd_q     <= '0;
    end else begin
      if (state == IDLE && take) begin
        grant <= grant_nxt;
        if (grant_nxt == GNT_A) begin
          is_write <= a_write;
          addr_q   <= a_address;
          wdata_q  <= a_writedata;
        end else begin
          is_write <= b_write;
          addr_q   <= b_address;
          wdata_q  <= b_writedata;
        end
      end
      if (state == ISSUE && !is_write) begin
        if (grant == GNT_A) begin
          a_rd_q <= pio_readdata;
        end else begin
          b_rd_q <= pio_readdata;
        end
      end
      if (state == DONE) begin
        last_grant <= grant;
      end
    end
  end

  // Phase-decoded outputs; readdata registers hold between completions.
  always_comb begin
    pio_chipselect  = (state == ISSUE);
    pio_write_n     = !((state == ISSUE) && is_write);
    pio_address     = addr_q;
    pio_writedata   = wdata_q;
    a_waitrequest   = !((state == DONE) && (grant == GNT_A));
    b_waitrequest   = !((state == DONE) && (grant == GNT_B));
    a_readdatavalid = (state == DONE) && (grant == GNT_A) && !is_write;
    b_readdatavalid = (state == DONE) && (grant == GNT_B) && !is_write;
    a_readdata      = a_rd_q;
    b_readdata      = b_rd_q;
  end

endmodule
